// File: rtl/alu_issue_unit.sv
// Command FIFO and result register in front of a combinational 32-bit ALU.
// Optional operand forwarding from the last issued result: ALU_ISSUE_FWD_EN.
module alu_issue_unit #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_f,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic             cmd_use_prev,
  output logic [3:0]       alu_f,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_y,
  input  logic [3:0]       alu_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_y,
  output logic [3:0]       res_zero,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

  logic [3:0]  f_mem [DEPTH];
  logic [31:0] a_mem [DEPTH];
  logic [31:0] b_mem [DEPTH];

  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg, count_next;
  logic             res_valid_reg, res_valid_next;
  logic [31:0]      res_y_reg;
  logic [3:0]       res_zero_reg;
  logic [CNT_W-1:0] op_count_reg;
  state_t           state_reg, state_next;
  logic             empty, push, pop, drain;

  assign empty     = (count_reg == '0);
  assign cmd_ready = (count_reg != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = !empty && (!res_valid_reg || res_ready);
  assign drain     = res_valid_reg && res_ready;

  assign res_valid = res_valid_reg;
  assign res_y     = res_y_reg;
  assign res_zero  = res_zero_reg;
  assign op_count  = op_count_reg;
  assign busy      = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      f_mem[wr_ptr_reg] <= cmd_f;
      a_mem[wr_ptr_reg] <= cmd_a;
      b_mem[wr_ptr_reg] <= cmd_b;
    end
  end

`ifdef ALU_ISSUE_FWD_EN
  logic        prev_mem [DEPTH];
  logic [31:0] fwd_y_reg;

  always_ff @(posedge clk) begin
    if (push) prev_mem[wr_ptr_reg] <= cmd_use_prev;
  end

  // Tracks every issue, whether or not the consumer has taken the result yet.
  always_ff @(posedge clk) begin
    if (reset)    fwd_y_reg <= '0;
    else if (pop) fwd_y_reg <= alu_y;
  end
`else
  logic unused_use_prev;
  assign unused_use_prev = cmd_use_prev;
`endif

  always_comb begin
    alu_f = '0;
    alu_a = '0;
    alu_b = '0;
    if (!empty) begin
      alu_f = f_mem[rd_ptr_reg];
      alu_b = b_mem[rd_ptr_reg];
`ifdef ALU_ISSUE_FWD_EN
      alu_a = prev_mem[rd_ptr_reg] ? fwd_y_reg : a_mem[rd_ptr_reg];
`else
      alu_a = a_mem[rd_ptr_reg];
`endif
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
    res_valid_next = res_valid_reg;
    if (pop)        res_valid_next = 1'b1;
    else if (drain) res_valid_next = 1'b0;
  end

  // busy reflects the state register, so IDLE is entered exactly when both
  // the FIFO and the result stage will be empty after this edge.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (push) state_next = RUN;
      RUN: begin
        if (count_next == '0 && !res_valid_next)           state_next = IDLE;
        else if (res_valid_reg && !res_ready && !empty)    state_next = STALL;
      end
      STALL: begin
        if (count_next == '0 && !res_valid_next) state_next = IDLE;
        else if (res_ready)                      state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      res_valid_reg <= 1'b0;
      res_y_reg     <= '0;
      res_zero_reg  <= '0;
      op_count_reg  <= '0;
      state_reg     <= IDLE;
    end else begin
      count_reg     <= count_next;
      res_valid_reg <= res_valid_next;
      state_reg     <= state_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop) begin
        rd_ptr_reg   <= rd_ptr_reg + AW'(1);
        res_y_reg    <= alu_y;
        res_zero_reg <= alu_zero;
      end
      if (drain) op_count_reg <= op_count_reg + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with an adder standing in for the ALU.
module tb_alu_issue_unit;
  logic        clk, reset;
  logic        cmd_valid, cmd_ready, cmd_use_prev;
  logic [3:0]  cmd_f, alu_f, alu_zero, res_zero;
  logic [31:0] cmd_a, cmd_b, alu_a, alu_b, alu_y, res_y;
  logic        res_valid, res_ready, busy;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;

  alu_issue_unit #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_f(cmd_f), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_prev(cmd_use_prev),
    .alu_f(alu_f), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_y(res_y), .res_zero(res_zero),
    .busy(busy), .op_count(op_count)
  );

  assign alu_y    = alu_a + alu_b;
  assign alu_zero = {3'b000, (alu_a + alu_b) == 32'd0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic up);
    cmd_valid    = v;
    cmd_f        = 4'h2;
    cmd_a        = a;
    cmd_b        = b;
    cmd_use_prev = up;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    res_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    do_reset();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_y", res_y, 32'd0);
    chk("rst_res_zero", 32'(res_zero), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);

    // Single command: visible at the ALU after one edge, result after two.
    res_ready = 1'b1;
    drive(1'b1, 32'd5, 32'd7, 1'b0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    chk("single_alu_f", 32'(alu_f), 32'h2);
    chk("single_alu_a", alu_a, 32'd5);
    chk("single_alu_b", alu_b, 32'd7);
    chk("single_early_valid", 32'(res_valid), 32'd0);
    chk("single_busy", 32'(busy), 32'd1);
    tick();
    chk("single_valid", 32'(res_valid), 32'd1);
    chk("single_y", res_y, 32'd12);
    chk("single_zero", 32'(res_zero), 32'd0);
    tick();
    chk("single_op_count", 32'(op_count), 32'd1);
    chk("single_drained", 32'(res_valid), 32'd0);
    chk("single_idle", 32'(busy), 32'd0);

    // Zero flag.
    drive(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    chk("zero_y", res_y, 32'd0);
    chk("zero_flag", 32'(res_zero), 32'd1);
    tick();
    chk("zero_op_count", 32'(op_count), 32'd2);

    // Backpressure: one result held, four queued, sixth command refused.
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'(100 + k), 32'(k), 1'b0);
      tick();
    end
    drive(1'b1, 32'd105, 32'd5, 1'b0);
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    chk("full_still_full", 32'(cmd_ready), 32'd0);
    tick();
    chk("full_hold_valid", 32'(res_valid), 32'd1);
    chk("full_hold_y", res_y, 32'd100);
    chk("full_head_a", alu_a, 32'd101);
    chk("full_busy", 32'(busy), 32'd1);
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("drain_valid_%0d", k), 32'(res_valid), 32'd1);
      chk($sformatf("drain_y_%0d", k), res_y, 32'(100 + 2 * k));
      tick();
    end
    chk("drain_done_valid", 32'(res_valid), 32'd0);
    chk("drain_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_op_count", 32'(op_count), 32'd7);

    // Streaming: one result per cycle from a clean counter.
    do_reset();
    chk("stream_rst_count", 32'(op_count), 32'd0);
    for (int i = 0; i < 21; i++) begin
      if (i < 20) drive(1'b1, 32'(i), 32'(2 * i), 1'b0);
      else        drive(1'b0, 32'd0, 32'd0, 1'b0);
      tick();
      if (i >= 1) begin
        chk($sformatf("stream_valid_%0d", i - 1), 32'(res_valid), 32'd1);
        chk($sformatf("stream_y_%0d", i - 1), res_y, 32'(3 * (i - 1)));
      end
    end
    tick();
    chk("stream_end_valid", 32'(res_valid), 32'd0);
    chk("stream_op_count", 32'(op_count), 32'd20);

    // Reset with three queued entries and a pending result.
    res_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'(50 + k), 32'd1, 1'b0);
      tick();
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    chk("mid_pre_valid", 32'(res_valid), 32'd1);
    chk("mid_pre_y", res_y, 32'd51);
    do_reset();
    chk("mid_valid", 32'(res_valid), 32'd0);
    chk("mid_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_op_count", 32'(op_count), 32'd0);
    chk("mid_res_y", res_y, 32'd0);
    chk("mid_alu_a", alu_a, 32'd0);
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("mid_no_stale_%0d", k), 32'(res_valid), 32'd0);
    end

    // Forwarding select on the second command.
    drive(1'b1, 32'd10, 32'd5, 1'b0);
    tick();
    drive(1'b1, 32'd999, 32'd1, 1'b1);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    chk("fwd_first_y", res_y, 32'd15);
    tick();
`ifdef ALU_ISSUE_FWD_EN
    chk("fwd_second_y", res_y, 32'd16);
`else
    chk("fwd_second_y", res_y, 32'd1000);
`endif
    chk("fwd_second_valid", 32'(res_valid), 32'd1);
    tick();
    chk("fwd_op_count", 32'(op_count), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
